// File: rtl/booth_controller.sv
// Sequencing FSM for the radix-2 Booth multiplier datapath.
// Loads operands, runs N evaluate/shift steps, then uploads {A,X}.
module booth_controller #(
    parameter int N     = 5,
    parameter int CNT_W = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] decision_bits,
    output logic       ldY,
    output logic       ldX,
    output logic       clrX,
    output logic       shX,
    output logic       ldA,
    output logic       shA,
    output logic       clrA,
    output logic       lde,
    output logic       clre,
    output logic       add,
    output logic       sub,
    output logic [1:0] upload_selector,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        LD_Y,
        LD_X,
        EVAL,
        SHIFT,
        UP_HI,
        UP_LO,
        DONE
    } state_t;

    state_t state;
    state_t nextState;
    logic [CNT_W-1:0] iterCount;
    logic lastIter;

    assign lastIter = (iterCount == CNT_W'(N - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iterCount <= '0;
        end else if (state == LD_X) begin
            iterCount <= '0;
        end else if (state == SHIFT) begin
            iterCount <= iterCount + 1'b1;
        end
    end

    always_comb begin
        nextState       = state;
        ldY             = 1'b0;
        ldX             = 1'b0;
        clrX            = 1'b0;
        shX             = 1'b0;
        ldA             = 1'b0;
        shA             = 1'b0;
        clrA            = 1'b0;
        lde             = 1'b0;
        clre            = 1'b0;
        add             = 1'b0;
        sub             = 1'b0;
        upload_selector = 2'b00;
        busy            = 1'b1;
        done            = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    nextState = LD_Y;
                end
            end
            LD_Y: begin
                ldY       = 1'b1;
                nextState = LD_X;
            end
            LD_X: begin
                ldX       = 1'b1;
                clrA      = 1'b1;
                clre      = 1'b1;
                nextState = EVAL;
            end
            EVAL: begin
                // {X[0],E}: 10 starts a run of ones, 01 ends one
                if (decision_bits == 2'b10) begin
                    sub = 1'b1;
                    ldA = 1'b1;
                end else if (decision_bits == 2'b01) begin
                    add = 1'b1;
                    ldA = 1'b1;
                end
                nextState = SHIFT;
            end
            SHIFT: begin
                shA       = 1'b1;
                shX       = 1'b1;
                lde       = 1'b1;
                nextState = lastIter ? UP_HI : EVAL;
            end
            UP_HI: begin
                upload_selector = 2'b10;
                nextState       = UP_LO;
            end
            UP_LO: begin
                upload_selector = 2'b01;
                nextState       = DONE;
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_controller.sv
// Directed bench for booth_controller with a behavioural 5-bit
// Booth datapath closing the decision_bits loop.
module tb_booth_controller;

    localparam int N = 5;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] decision_bits;
    logic       ldY, ldX, clrX, shX, ldA, shA, clrA;
    logic       lde, clre, add, sub, busy, done;
    logic [1:0] upload_selector;

    logic [4:0] yOp, xOp;
    logic [4:0] inbus, outP;
    logic [4:0] mA, mX, mY;
    logic       mE;
    logic [14:0] allOut;

    int checks = 0;
    int errors = 0;

    booth_controller #(.N(N), .CNT_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .decision_bits(decision_bits),
        .ldY(ldY),
        .ldX(ldX),
        .clrX(clrX),
        .shX(shX),
        .ldA(ldA),
        .shA(shA),
        .clrA(clrA),
        .lde(lde),
        .clre(clre),
        .add(add),
        .sub(sub),
        .upload_selector(upload_selector),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign allOut = {ldY, ldX, clrX, shX, ldA, shA, clrA, lde,
                     clre, add, sub, upload_selector, busy, done};

    // Requester and datapath model
    assign inbus = ldY ? yOp : (ldX ? xOp : 5'b0);
    assign decision_bits = {mX[0], mE};
    assign outP = (upload_selector == 2'b10) ? mA :
                  (upload_selector == 2'b01) ? mX : 5'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mA <= '0;
            mX <= '0;
            mY <= '0;
            mE <= 1'b0;
        end else begin
            if (ldY) mY <= inbus;
            if (ldX) mX <= inbus;
            if (clrA) mA <= '0;
            if (clre) mE <= 1'b0;
            if (ldA) mA <= add ? mA + mY : mA - mY;
            if (shA) mA <= {mA[4], mA[4:1]};
            if (shX) mX <= {mA[0], mX[4:1]};
            if (lde) mE <= mX[0];
        end
    end

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("inv_addsub", 16'(add & sub), 16'd0);
            check("inv_ldA", 16'(ldA & ~(add | sub)), 16'd0);
            check("inv_shld", 16'(ldA & (shA | shX | lde)), 16'd0);
            check("inv_ldYX", 16'(ldY & ldX), 16'd0);
            check("inv_clrX", 16'(clrX), 16'd0);
        end
    end

    function automatic logic [2:0] opBits(input logic [1:0] op);
        // returns {add,sub,ldA}; 1 = add, 2 = sub, else none
        case (op)
            2'd1:    return 3'b101;
            2'd2:    return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    // ops: iteration i's expected op in ops[2*i +: 2]
    task automatic runOp(input string tag, input logic [4:0] yv,
                         input logic [4:0] xv, input logic [9:0] ops,
                         input logic [4:0] hi, input logic [4:0] lo);
        yOp = yv;
        xOp = xv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_ldY"}, 16'({ldY, ldX, busy}), 16'b101);
        @(negedge clk);
        check({tag, "_ldX"}, 16'({ldY, ldX, clrA, clre}), 16'b0111);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            check($sformatf("%s_eval%0d", tag, i),
                  16'({add, sub, ldA}), 16'(opBits(ops[2*i +: 2])));
            check($sformatf("%s_evsh%0d", tag, i),
                  16'({shA, shX, lde}), 16'd0);
            @(negedge clk);
            check($sformatf("%s_shift%0d", tag, i),
                  16'({shA, shX, lde, ldA}), 16'b1110);
        end
        @(negedge clk);
        check({tag, "_selHi"}, 16'(upload_selector), 16'b10);
        check({tag, "_outHi"}, 16'(outP), 16'(hi));
        @(negedge clk);
        check({tag, "_selLo"}, 16'(upload_selector), 16'b01);
        check({tag, "_outLo"}, 16'(outP), 16'(lo));
        @(negedge clk);
        check({tag, "_done"}, 16'({done, busy}), 16'b11);
        @(negedge clk);
        check({tag, "_idle"}, 16'({done, busy}), 16'b00);
    endtask

    int doneCnt, doneAt0, doneAt1, ldYCnt, ldYAt1, ldYAt2, busyBad;
    bit drained;

    initial begin
        rst = 1'b0;
        start = 1'b0;
        yOp = '0;
        xOp = '0;
        #1;
        check("reset_outs", 16'(allOut), 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_idle", 16'(allOut), 16'd0);

        // 3 x 5 = 15: sub, add, sub, add, none
        runOp("p3x5", 5'b00011, 5'b00101,
              {2'd0, 2'd1, 2'd2, 2'd1, 2'd2}, 5'b00000, 5'b01111);
        // -3 x 5 = -15
        runOp("m3x5", 5'b11101, 5'b00101,
              {2'd0, 2'd1, 2'd2, 2'd1, 2'd2}, 5'b11111, 5'b10001);
        // 7 x -1 = -7: one sub then only 11 decisions
        runOp("p7xm1", 5'b00111, 5'b11111,
              {2'd0, 2'd0, 2'd0, 2'd0, 2'd2}, 5'b11111, 5'b11001);

        // asynchronous abort in the middle of a SHIFT cycle
        yOp = 5'b00011;
        xOp = 5'b00101;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_inshift", 16'({shA, busy}), 16'b11);
        #2 rst = 1'b0;
        #1;
        check("abort_async", 16'(allOut), 16'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_idle", 16'(allOut), 16'd0);
        @(negedge clk);
        check("abort_stay", 16'(busy), 16'd0);

        // start pulse while busy is ignored
        doneCnt = 0;
        doneAt0 = 0;
        ldYCnt = 0;
        busyBad = 0;
        start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start = (k == 4);
            if (done) begin
                doneCnt++;
                doneAt0 = k;
            end
            if (ldY) ldYCnt++;
            if (busy != (k <= 15)) busyBad++;
        end
        check("busy_doneCnt", 16'(doneCnt), 16'd1);
        check("busy_doneAt", 16'(doneAt0), 16'd15);
        check("busy_ldYCnt", 16'(ldYCnt), 16'd1);
        check("busy_level", 16'(busyBad), 16'd0);

        // start held high: back-to-back operations
        doneCnt = 0;
        doneAt0 = 0;
        doneAt1 = 0;
        ldYCnt = 0;
        ldYAt1 = 0;
        ldYAt2 = 0;
        start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                if (doneCnt == 0) doneAt0 = k;
                else if (doneCnt == 1) doneAt1 = k;
                doneCnt++;
            end
            if (ldY) begin
                if (ldYCnt == 1) ldYAt1 = k;
                else if (ldYCnt == 2) ldYAt2 = k;
                ldYCnt++;
            end
        end
        start = 1'b0;
        check("held_doneCnt", 16'(doneCnt), 16'd2);
        check("held_done0", 16'(doneAt0), 16'd15);
        check("held_done1", 16'(doneAt1), 16'd31);
        check("held_ldYCnt", 16'(ldYCnt), 16'd3);
        check("held_ldY1", 16'(ldYAt1), 16'd17);
        check("held_ldY2", 16'(ldYAt2), 16'd33);

        drained = 1'b0;
        for (int k = 0; k < 30 && !drained; k++) begin
            @(negedge clk);
            if (!busy) drained = 1'b1;
        end
        check("held_drain", 16'(drained), 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_controller.md
Name: booth_controller

Overview:
- Sequencing FSM for the 5-bit radix-2 Booth multiplier datapath.
- Accepts a start request and steps the requester through operand loading on the shared inbus.
- Runs N evaluate/shift iterations driven by the datapath decision bits, then presents the product on outP as two words (A high, X low).
- Sits between the system requester and the datapath; it drives every datapath control strobe.

Parameters:
- N, 5: operand width and iteration count; must match the datapath width.
- CNT_W, 3: iteration counter width; must satisfy 2^CNT_W > N.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a multiply; sampled only in IDLE.
- decision_bits  input  2  {X[0], E} from datapath.
- ldY  output  1  load multiplicand from inbus; requester drives multiplicand on inbus this cycle.
- ldX  output  1  load multiplier from inbus; requester drives multiplier on inbus this cycle.
- clrX  output  1  clear X register; tied 0 in this design.
- shX  output  1  shift X right, A[0] shifted in.
- ldA  output  1  load ALU result into A.
- shA  output  1  arithmetic right shift of A.
- clrA  output  1  clear A.
- lde  output  1  load E from X[0].
- clre  output  1  clear E.
- add  output  1  ALU computes A+Y.
- sub  output  1  ALU computes A-Y.
- upload_selector  output  2  01 = X on outP, 10 = A on outP, 00 otherwise.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the product upload completes.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, all outputs 0. Reset mid-operation aborts immediately; the datapath register contents are don't-care afterwards.
- All outputs are Moore-decoded from the registered state, except add/sub/ldA in EVAL, which also decode decision_bits.
- States and transitions:
  - IDLE: all strobes 0. start=1 -> LD_Y, else stay.
  - LD_Y: ldY=1 -> LD_X.
  - LD_X: ldX=1, clrA=1, clre=1, counter<=0 -> EVAL.
  - EVAL: decision 10 -> sub=1, ldA=1; 01 -> add=1, ldA=1; 00 or 11 -> no strobes. Always -> SHIFT; the cycle is spent even with no operation (fixed latency).
  - SHIFT: shA=1, shX=1, lde=1; counter<=counter+1. If counter==N-1 -> UP_HI, else -> EVAL.
  - UP_HI: upload_selector=10 -> UP_LO.
  - UP_LO: upload_selector=01 -> DONE.
  - DONE: done=1 -> IDLE.
- Timing: start sampled high at edge t0. ldY in t1, ldX in t2, EVAL/SHIFT pairs in t3..t(2+2N), UP_HI t(3+2N), UP_LO t(4+2N), done t(5+2N). For N=5, done is in cycle t15, 15 cycles after start.
- Invariants:
  - add and sub are never both 1.
  - ldA is 1 only with add or sub.
  - shA/shX/lde are never asserted in the same cycle as ldA.
  - ldY and ldX are never both 1.
- start while busy is ignored and not queued. start held high continuously gives back-to-back operations: IDLE re-samples start the cycle after DONE.
- Counter wraps are not possible: it is cleared in LD_X and the exit happens at N-1.
- Product is signed two's complement 2N bits = {A,X}, valid on outP in UP_HI (A) and UP_LO (X).

Test Plan:
- Reset: assert rst=0 mid-SHIFT -> all outputs 0 immediately (async); after release, state IDLE, busy=0.
- 3 x 5: Y=00011, X=00101. Strobe trace must be EVAL ops sub, add, sub, add, none. Then outP=00000 in UP_HI, 01111 in UP_LO; done at t15.
- -3 x 5: Y=11101, X=00101 -> outP=11111 then 10001 (-15); done at t15.
- Decision 11 and 00 (X=11111, Y=00111) -> first EVAL is sub; later EVALs have no add/sub/ldA; product {11111,11001} = -7.
- start pulsed at t5 during busy -> ignored; exactly one done pulse; busy stays 1 until DONE.
- start held high for 40 cycles -> done pulses at t15 and t31; ldY is asserted the cycle after IDLE each time.
